// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 main memory: single-write, dual-read synchronous RAM with a boot sequencer
// (clear + hex font) and a byte-stream program loader starting at PROG_BASE.
module chip8_mem_ctrl #(
    parameter int               ADDR_W         = 12,
    parameter int               DATA_W         = 8,
    parameter logic [ADDR_W-1:0] FONT_BASE     = 'h050,
    parameter logic [ADDR_W-1:0] PROG_BASE     = 'h200,
    parameter bit               CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] ld_count,
    output logic              ld_overflow,
    output logic              init_done
);
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int FONT_LEN = 80;

    localparam logic [0:FONT_LEN-1][7:0] FONT = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    typedef enum logic [1:0] {INIT_CLEAR, INIT_FONT, RUN, LOAD} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_cnt;
    logic [6:0]        font_cnt;
    logic [ADDR_W:0]   ld_cnt;
    logic [ADDR_W:0]   ld_sum;
    logic              ld_drop, ld_acc, a_acc, b_act;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign a_ready  = (state == RUN);
    assign ld_ready = (state == LOAD);
    assign b_act    = (state == RUN) || (state == LOAD);
    assign a_acc    = a_en & a_ready;
    assign ld_acc   = ld_valid & ld_ready;
    // One extra bit so a target past DEPTH-1 shows up as a carry instead of wrapping.
    assign ld_sum   = {1'b0, PROG_BASE} + ld_cnt;
    assign ld_drop  = ld_sum[ADDR_W];
    assign ld_count = ld_cnt[ADDR_W-1:0];

    always_comb begin
        state_nx = state;
        we       = 1'b0;
        waddr    = clr_cnt;
        wdata    = '0;
        case (state)
            INIT_CLEAR: begin
                we = 1'b1;
                if (&clr_cnt) state_nx = INIT_FONT;
            end
            INIT_FONT: begin
                we    = 1'b1;
                waddr = FONT_BASE + ADDR_W'(font_cnt);
                wdata = DATA_W'(FONT[font_cnt]);
                if (font_cnt == 7'(FONT_LEN - 1)) state_nx = RUN;
            end
            RUN: begin
                we    = a_acc & a_we;
                waddr = a_addr;
                wdata = a_wdata;
                if (ld_start) state_nx = LOAD;
            end
            LOAD: begin
                we    = ld_acc & ~ld_drop;
                waddr = ld_sum[ADDR_W-1:0];
                wdata = ld_data;
                if (ld_acc && ld_last) state_nx = RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state <= INIT_CLEAR;
            else                state <= INIT_FONT;
            clr_cnt     <= '0;
            font_cnt    <= '0;
            ld_cnt      <= '0;
            ld_overflow <= 1'b0;
            init_done   <= 1'b0;
            a_rdata     <= '0;
            a_rvalid    <= 1'b0;
            b_rdata     <= '0;
            b_rvalid    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == INIT_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (state == INIT_FONT)  font_cnt <= font_cnt + 1'b1;
            if (state == INIT_FONT && state_nx == RUN) init_done <= 1'b1;
            if (state == RUN && ld_start) begin
                ld_cnt      <= '0;
                ld_overflow <= 1'b0;
            end else if (ld_acc) begin
                if (ld_drop) ld_overflow <= 1'b1;
                else         ld_cnt      <= ld_cnt + 1'b1;
            end
            // Read-first: a write cycle still captures the old word but does not flag it.
            a_rvalid <= a_acc & ~a_we;
            if (a_acc) a_rdata <= mem[a_addr];
            b_rvalid <= b_en & b_act;
            if (b_en && b_act) b_rdata <= mem[b_addr];
        end
    end
endmodule

// File: tb/tb_chip8_mem_ctrl.sv
// Bench for chip8_mem_ctrl: random port A/B traffic and loader streams against an
// array model of memory contents; a second 10-bit instance covers loader overflow.
module tb_chip8_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_en = 0, a_we = 0, a_ready, a_rvalid;
    logic [11:0] a_addr = 0;
    logic [7:0]  a_wdata = 0, a_rdata;
    logic        b_en = 0, b_rvalid;
    logic [11:0] b_addr = 0;
    logic [7:0]  b_rdata;
    logic        ld_start = 0, ld_valid = 0, ld_last = 0, ld_ready, ld_overflow, init_done;
    logic [7:0]  ld_data = 0;
    logic [11:0] ld_count;

    logic        l_a_en = 0, l_a_we = 0, l_a_ready, l_a_rvalid;
    logic [9:0]  l_a_addr = 0, l_b_addr = 0, l_ld_count;
    logic [7:0]  l_a_wdata = 0, l_a_rdata, l_b_rdata, l_ld_data = 0;
    logic        l_b_en = 0, l_b_rvalid;
    logic        l_ld_start = 0, l_ld_valid = 0, l_ld_last = 0, l_ld_ready, l_ld_overflow, l_init_done;

    chip8_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_count(ld_count), .ld_overflow(ld_overflow),
        .init_done(init_done)
    );

    chip8_mem_ctrl #(.ADDR_W(10), .FONT_BASE(10'h050), .PROG_BASE(10'h200)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .a_en(l_a_en), .a_we(l_a_we), .a_addr(l_a_addr), .a_wdata(l_a_wdata),
        .a_ready(l_a_ready), .a_rdata(l_a_rdata), .a_rvalid(l_a_rvalid),
        .b_en(l_b_en), .b_addr(l_b_addr), .b_rdata(l_b_rdata), .b_rvalid(l_b_rvalid),
        .ld_start(l_ld_start), .ld_valid(l_ld_valid), .ld_data(l_ld_data), .ld_last(l_ld_last),
        .ld_ready(l_ld_ready), .ld_count(l_ld_count), .ld_overflow(l_ld_overflow),
        .init_done(l_init_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image plus the registered read outputs it implies.
    logic [7:0] font_t [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };
    logic [7:0] rmem [4096];
    logic [7:0] exp_ad, exp_bd;
    int         cnt;
    bit         ovf;
    logic [7:0] ldq [$];
    logic [7:0] img10 [600];

    task automatic model_boot();
        foreach (rmem[i]) rmem[i] = 8'h00;
        foreach (font_t[i]) rmem['h050 + i] = font_t[i];
        exp_ad = 0;
        exp_bd = 0;
        cnt = 0;
        ovf = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from reset release to init_done while poking both ports during init.
    task automatic wait_boot(output int nb, output int n10);
        bit pulse;
        nb = 0;
        n10 = 0;
        for (int n = 1; n <= 5000; n++) begin
            pulse = (n <= 10) || (n > 4100 && n <= 4110);
            a_en = pulse; a_we = (n % 2 == 1); a_addr = 12'h300; a_wdata = 8'hFF;
            b_en = pulse; b_addr = 12'h050;
            step();
            if (pulse) begin
                chk("init_a_rvalid", 32'(a_rvalid), 0);
                chk("init_b_rvalid", 32'(b_rvalid), 0);
                chk("init_a_ready", 32'(a_ready), 0);
                chk("init_b_rdata", 32'(b_rdata), 0);
            end
            if (l_init_done && n10 == 0) n10 = n;
            if (init_done) begin
                nb = n;
                break;
            end
        end
        a_en = 0;
        b_en = 0;
    endtask

    task automatic run_cyc(input bit ae, input bit awe, input logic [11:0] aa,
                           input logic [7:0] ad, input bit be, input logic [11:0] ba);
        a_en = ae; a_we = awe; a_addr = aa; a_wdata = ad;
        b_en = be; b_addr = ba;
        if (be) exp_bd = rmem[ba];
        if (ae) exp_ad = rmem[aa];
        if (ae && awe) rmem[aa] = ad;
        step();
        chk("a_rvalid", 32'(a_rvalid), 32'(ae & !awe));
        chk("a_rdata", 32'(a_rdata), 32'(exp_ad));
        chk("b_rvalid", 32'(b_rvalid), 32'(be));
        chk("b_rdata", 32'(b_rdata), 32'(exp_bd));
        a_en = 0;
        b_en = 0;
    endtask

    // Streams ldq; the ld_start cycle also carries a port A read, which must complete.
    task automatic load_q();
        logic [11:0] ra;
        logic [11:0] rb;
        int          tgt;
        ra = 12'($urandom);
        ld_start = 1; a_en = 1; a_we = 0; a_addr = ra; exp_ad = rmem[ra];
        step();
        ld_start = 0; a_en = 0; cnt = 0; ovf = 0;
        chk("ldst_a_rvalid", 32'(a_rvalid), 1);
        chk("ldst_a_rdata", 32'(a_rdata), 32'(exp_ad));
        chk("ldst_ld_ready", 32'(ld_ready), 1);
        chk("ldst_a_ready", 32'(a_ready), 0);
        chk("ldst_ld_count", 32'(ld_count), 0);
        chk("ldst_ovf", 32'(ld_overflow), 0);
        foreach (ldq[i]) begin
            repeat ($urandom_range(0, 2)) begin
                ld_valid = 0;
                a_en = 1; a_we = 1; a_addr = ra; a_wdata = ~rmem[ra];
                rb = 12'($urandom);
                b_en = 1; b_addr = rb; exp_bd = rmem[rb];
                step();
                chk("load_a_rvalid", 32'(a_rvalid), 0);
                chk("load_a_rdata", 32'(a_rdata), 32'(exp_ad));
                chk("load_b_rvalid", 32'(b_rvalid), 1);
                chk("load_b_rdata", 32'(b_rdata), 32'(exp_bd));
                a_en = 0;
                b_en = 0;
            end
            ld_valid = 1; ld_data = ldq[i]; ld_last = (i == ldq.size() - 1);
            tgt = 'h200 + cnt;
            if (tgt <= 4095) begin
                rmem[tgt] = ldq[i];
                cnt++;
            end else begin
                ovf = 1;
            end
            step();
            chk("ld_count", 32'(ld_count), 32'(cnt));
            chk("ld_overflow", 32'(ld_overflow), 32'(ovf));
        end
        ld_valid = 0;
        ld_last = 0;
        chk("ldend_ld_ready", 32'(ld_ready), 0);
        chk("ldend_a_ready", 32'(a_ready), 1);
    endtask

    task automatic scan();
        for (int i = 0; i < 4096; i++) run_cyc(0, 0, 12'h000, 8'h00, 1, 12'(i));
    endtask

    initial begin
        int nb, n10, len;
        logic [11:0] aa, ba;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_b_rvalid", 32'(b_rvalid), 0);
        rst_n = 1;
        wait_boot(nb, n10);
        chk("boot_cycles", 32'(nb), 4176);
        chk("boot10_cycles", 32'(n10), 1104);
        model_boot();
        chk("run_a_ready", 32'(a_ready), 1);
        scan();
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'h050);
        chk("font_050", 32'(b_rdata), 32'hF0);
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'h09F);
        chk("font_09F", 32'(b_rdata), 32'h80);
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'hFFF);
        chk("clear_FFF", 32'(b_rdata), 32'h00);

        run_cyc(1, 1, 12'h300, 8'hA5, 1, 12'h300);
        chk("wr_b_old", 32'(b_rdata), 32'h00);
        run_cyc(1, 0, 12'h300, 8'h00, 0, 12'h000);
        chk("rd_a_300", 32'(a_rdata), 32'hA5);
        chk("rd_a_rvalid", 32'(a_rvalid), 1);
        run_cyc(0, 0, 12'h000, 8'h00, 0, 12'h000);

        ldq = '{8'h12, 8'h34, 8'h56};
        load_q();
        chk("ld3_count", 32'(ld_count), 3);
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'h200);
        chk("ld3_200", 32'(b_rdata), 32'h12);
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'h202);
        chk("ld3_202", 32'(b_rdata), 32'h56);

        for (int k = 0; k < 600; k++) begin
            aa = ($urandom_range(0, 1) == 1) ? 12'h300 + 12'($urandom_range(0, 15)) : 12'($urandom);
            ba = ($urandom_range(0, 1) == 1) ? 12'h300 + 12'($urandom_range(0, 15)) : 12'($urandom);
            run_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, 8'($urandom),
                    1'($urandom_range(0, 1)), ba);
        end
        for (int k = 0; k < 3; k++) begin
            len = $urandom_range(1, 24);
            ldq = {};
            for (int j = 0; j < len; j++) ldq.push_back(8'($urandom));
            load_q();
        end

        l_ld_start = 1;
        step();
        l_ld_start = 0;
        chk("l_ld_ready", 32'(l_ld_ready), 1);
        for (int i = 0; i < 600; i++) begin
            img10[i] = 8'($urandom);
            l_ld_valid = 1; l_ld_data = img10[i]; l_ld_last = (i == 599);
            step();
            if (i == 511) chk("l_ovf_511", 32'(l_ld_overflow), 0);
            if (i == 512) chk("l_ovf_512", 32'(l_ld_overflow), 1);
        end
        l_ld_valid = 0;
        l_ld_last = 0;
        chk("l_ld_count", 32'(l_ld_count), 512);
        chk("l_ld_overflow", 32'(l_ld_overflow), 1);
        chk("l_ld_ready_end", 32'(l_ld_ready), 0);
        l_b_en = 1; l_b_addr = 10'h3FF;
        step();
        chk("l_3FF", 32'(l_b_rdata), 32'(img10[511]));
        l_b_addr = 10'h200;
        step();
        chk("l_200", 32'(l_b_rdata), 32'(img10[0]));
        l_b_addr = 10'h000;
        step();
        chk("l_000", 32'(l_b_rdata), 0);
        l_b_en = 0;

        scan();

        run_cyc(1, 0, 12'h050, 8'h00, 1, 12'h051);
        ld_start = 1;
        step();
        ld_start = 0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_data = 8'h11 + 8'(i);
            step();
        end
        ld_valid = 0;
        chk("mid_ld_count", 32'(ld_count), 5);
        rst_n = 0;
        #1;
        chk("arst_ld_ready", 32'(ld_ready), 0);
        chk("arst_ld_count", 32'(ld_count), 0);
        chk("arst_a_rdata", 32'(a_rdata), 0);
        chk("arst_b_rdata", 32'(b_rdata), 0);
        chk("arst_init_done", 32'(init_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        wait_boot(nb, n10);
        chk("reboot_cycles", 32'(nb), 4176);
        model_boot();
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'h200);
        chk("reboot_200", 32'(b_rdata), 0);
        run_cyc(0, 0, 12'h000, 8'h00, 1, 12'h050);
        chk("reboot_050", 32'(b_rdata), 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/chip8_mem_ctrl.md
Name: chip8_mem_ctrl

Overview:
- Parametrised successor to the CHIP-8 main memory: synchronous-read RAM with two ports and a self-initialising boot sequencer.
- Port A is the CPU read/write port. Port B is read-only, for the display/sprite fetch engine.
- After reset, the boot sequencer clears RAM and writes the built-in hex font.
- A byte-stream loader port then copies a game image to PROG_BASE, so no simulation-only file preload is needed.

Parameters:
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width; must be >=8; font bytes zero-extended.
- FONT_BASE, 12'h050, first address of the 80-byte font.
- PROG_BASE, 12'h200, first address written by the loader.
- CLEAR_ON_RESET, 1, 1 = zero all words before the font write; 0 = skip the clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ready  out  1  port A accepts requests (high only in RUN).
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  a_rdata valid pulse.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_W  port B address.
- b_rdata  out  DATA_W  port B read data.
- b_rvalid  out  1  b_rdata valid pulse.
- ld_start  in  1  one-cycle pulse: enter LOAD.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_W  loader byte.
- ld_last  in  1  marks the final byte.
- ld_ready  out  1  loader accepts a byte.
- ld_count  out  ADDR_W  bytes written in the current load.
- ld_overflow  out  1  sticky: a byte was dropped past DEPTH-1.
- init_done  out  1  boot sequence complete.

Behaviour:
- Reset (rst_n low, async): state = INIT_CLEAR, or INIT_FONT if CLEAR_ON_RESET = 0.
  - All outputs 0: a_ready, a_rvalid, b_rvalid, ld_ready, ld_count, ld_overflow, init_done; a_rdata and b_rdata = 0.
  - RAM contents are not reset; the boot sequence rewrites them.
- States: INIT_CLEAR -> INIT_FONT -> RUN <-> LOAD.
- INIT_CLEAR: internal counter writes 0 to address 0..DEPTH-1, one word per cycle, then goes to INIT_FONT.
- INIT_FONT: writes the 80-byte standard font (digits 0-F, 5 bytes each, e.g. 0 = F0 90 90 90 F0, F = F0 80 F0 80 80) to FONT_BASE..FONT_BASE+79, one per cycle.
  - After the last byte: init_done = 1 on the next edge, state = RUN.
  - init_done stays 1 until reset.
- Boot length: init_done rises DEPTH+80 cycles after rst_n deasserts (80 cycles if CLEAR_ON_RESET = 0).
- Port A and port B during INIT_* states: requests ignored; a_rvalid and b_rvalid stay 0; a_ready = 0.
- RUN:
  - a_ready = 1.
  - Port A request when a_en & a_ready:
    - a_we = 1: write at the edge.
    - a_we = 0: a_rdata updated at the same edge, a_rvalid = 1 for one cycle (1-cycle latency).
  - Write cycles also register old data into a_rdata (read-first) but do not pulse a_rvalid.
  - Port B: b_en -> b_rdata registered at the edge, b_rvalid pulses one cycle.
  - Port B is active in every state except INIT_*.
  - Port B reading the address port A writes in the same cycle returns the old data.
- ld_start in RUN: next state LOAD, ld_count = 0, ld_overflow cleared. ld_start is ignored in other states.
- LOAD:
  - a_ready = 0; port A requests ignored (CPU is halted by its controller); ld_ready = 1.
  - On ld_valid & ld_ready:
    - write ld_data to PROG_BASE + ld_count (ADDR_W arithmetic, no wrap);
    - ld_count += 1.
  - If PROG_BASE + ld_count would exceed DEPTH-1: the byte is dropped and ld_overflow is set (sticky); ld_count does not increment.
  - An accepted byte with ld_last = 1 is processed, then the next state is RUN.
  - ld_count holds its final value until the next ld_start.
- Reset mid-LOAD or mid-INIT: restarts the boot sequence from scratch; partial image lost.
- Simultaneous ld_start and a port A request in RUN: the port A request completes that cycle; LOAD starts next cycle.
- Single-write-port RAM: only one writer per cycle is possible by construction (sequencer in INIT_*, loader in LOAD, port A in RUN).
- Port B is a separate read port, so the RAM must map to true dual-port BRAM.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1, ADDR_W = 12 -> init_done rises exactly 4176 cycles later; port B reads of 0x000, 0x04F, 0xFFF return 00; 0x050 -> F0, 0x09F -> 80.
- Port A write 0x300 = A5, then read 0x300 -> a_rvalid exactly 1 cycle after the request, a_rdata = A5; same-cycle port B read of 0x300 during the write -> old value 00.
- ld_start, stream 12 34 56 (last on 56) -> ld_count = 3, RAM 0x200..0x202 = 12 34 56, state back to RUN, a_ready = 1.
- Load with ADDR_W = 10, PROG_BASE = 0x200: stream 600 bytes -> ld_count = 512, ld_overflow = 1, 0x3FF = byte 511, no wrap into 0x000.
- Assert rst_n low mid-LOAD -> outputs immediately 0; after rst_n rises, boot repeats and 0x200 reads 00.
- During INIT_CLEAR, pulse a_en and b_en -> a_rvalid and b_rvalid stay 0; no write lands.
